// File: rtl/mem_port_arbiter.sv
// Shared narrow memory bus front end: arbitrates fetch and data ports, splits each
// word into BEAT_W beats with a fixed read latency and reassembles the returned data.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEAT_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic [DATA_W-1:0]     if_data_o,
  output logic                  if_done_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  input  logic [DATA_W/8-1:0]   mem_sel_i,
  output logic [DATA_W-1:0]     mem_rdata_o,
  output logic                  mem_done_o,
  output logic                  bus_valid_o,
  output logic                  bus_we_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [BEAT_W-1:0]     bus_wdata_o,
  input  logic [BEAT_W-1:0]     bus_rdata_i,
  output logic                  stallreq_o
);

  localparam int N     = DATA_W / BEAT_W;
  localparam int BYTES = BEAT_W / 8;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, IF_XFER, MEM_XFER, DONE} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   base_reg;
  logic                we_reg;
  logic                served_mem_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   asm_reg, asm_next;
  logic [DATA_W-1:0]   if_data_reg, mem_rdata_reg;
  logic [N-1:0]        mask_reg, beat_en, wr_onehot;
  logic [CNT_W-1:0]    issue_cnt_reg, ret_cnt_reg, wr_beat, cur_beat;
  logic [RD_LAT-1:0]   pipe_reg, pipe_next;

  logic grant_mem, grant_if, xfer_rd, rd_issue, wr_issue;
  logic capture, last_capture, wr_last;

  // A write beat is needed only when some byte lane inside it is enabled.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_beat_en
      assign beat_en[gi] = |mem_sel_i[gi*BYTES +: BYTES];
    end
  endgenerate

  // Tie-break favours the port that was not served most recently.
  assign grant_mem = (state_reg == IDLE) && mem_req_i && (!if_req_i || !served_mem_reg);
  assign grant_if  = (state_reg == IDLE) && if_req_i && !grant_mem;

  assign xfer_rd      = (state_reg == IF_XFER) || ((state_reg == MEM_XFER) && !we_reg);
  assign rd_issue     = xfer_rd && (issue_cnt_reg < CNT_W'(N));
  assign wr_issue     = (state_reg == MEM_XFER) && we_reg && (|mask_reg);
  assign capture      = xfer_rd && pipe_reg[RD_LAT-1];
  assign last_capture = capture && (ret_cnt_reg == CNT_W'(N - 1));
  assign wr_last      = wr_issue && ((mask_reg & ~wr_onehot) == '0);
  assign cur_beat     = we_reg ? wr_beat : issue_cnt_reg;

  // Each pipe bit marks a read beat in flight; the top bit lines up with its data.
  generate
    if (RD_LAT == 1) begin : g_pipe_one
      assign pipe_next = rd_issue;
    end else begin : g_pipe_many
      assign pipe_next = {pipe_reg[RD_LAT-2:0], rd_issue};
    end
  endgenerate

  always_comb begin
    wr_beat   = '0;
    wr_onehot = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask_reg[k]) begin
        wr_beat      = CNT_W'(k);
        wr_onehot    = '0;
        wr_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    asm_next = asm_reg;
    for (int k = 0; k < N; k++) begin
      if (capture && (k == int'(ret_cnt_reg))) begin
        asm_next[k*BEAT_W +: BEAT_W] = bus_rdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_mem) begin
          state_next = (mem_we_i && (mem_sel_i == '0)) ? DONE : MEM_XFER;
        end else if (grant_if) begin
          state_next = IF_XFER;
        end
      end
      IF_XFER, MEM_XFER: begin
        if (last_capture || wr_last) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus_valid_o = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    if_done_o   = 1'b0;
    mem_done_o  = 1'b0;
    if (rd_issue || wr_issue) begin
      bus_valid_o = 1'b1;
      bus_we_o    = wr_issue;
      for (int k = 0; k < N; k++) begin
        if (k == int'(cur_beat)) begin
          bus_addr_o = base_reg + ADDR_W'(k * BYTES);
          if (wr_issue) begin
            bus_wdata_o = wdata_reg[k*BEAT_W +: BEAT_W];
          end
        end
      end
    end
    if (state_reg == DONE) begin
      if_done_o  = !served_mem_reg;
      mem_done_o = served_mem_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      base_reg       <= '0;
      we_reg         <= 1'b0;
      served_mem_reg <= 1'b0;
      wdata_reg      <= '0;
      asm_reg        <= '0;
      if_data_reg    <= '0;
      mem_rdata_reg  <= '0;
      mask_reg       <= '0;
      issue_cnt_reg  <= '0;
      ret_cnt_reg    <= '0;
      pipe_reg       <= '0;
    end else begin
      pipe_reg <= pipe_next;
      if (grant_mem || grant_if) begin
        served_mem_reg <= grant_mem;
        base_reg       <= grant_mem ? mem_addr_i : if_addr_i;
        we_reg         <= grant_mem && mem_we_i;
        wdata_reg      <= mem_wdata_i;
        mask_reg       <= (grant_mem && mem_we_i) ? beat_en : '0;
        issue_cnt_reg  <= '0;
        ret_cnt_reg    <= '0;
      end
      if (rd_issue) begin
        issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
      end
      if (wr_issue) begin
        mask_reg <= mask_reg & ~wr_onehot;
      end
      if (capture) begin
        asm_reg     <= asm_next;
        ret_cnt_reg <= ret_cnt_reg + CNT_W'(1);
      end
      if (last_capture) begin
        if (served_mem_reg) begin
          mem_rdata_reg <= asm_next;
        end else begin
          if_data_reg <= asm_next;
        end
      end
    end
  end

  assign if_data_o   = if_data_reg;
  assign mem_rdata_o = mem_rdata_reg;
  assign stallreq_o  = mem_req_i & ~mem_done_o;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised multi-cycle memory front end for the five-stage core.
- Replaces the single-cycle combinational ROM/RAM pair with one narrow shared memory bus.
- Arbitrates the instruction-fetch port and the data (MEM-stage) port. Splits each word access into BEAT_W-wide bus beats with a configurable read latency, then reassembles the read data.
- Raises a stall request to the pipeline controller while a data access is outstanding.

Parameters:
- ADDR_W, 32, byte-address width of both ports and the bus.
- DATA_W, 32, port word width; multiple of BEAT_W.
- BEAT_W, 8, bus data width per beat; multiple of 8.
- RD_LAT, 1, cycles from a read beat issue to its data on bus_rdata_i (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- if_req_i  in  1  fetch request, held until if_done_o
- if_addr_i  in  ADDR_W  fetch byte address
- if_data_o  out  DATA_W  fetched word, valid with if_done_o, held until next fetch completes
- if_done_o  out  1  one-cycle completion pulse
- mem_req_i  in  1  data request, held until mem_done_o
- mem_we_i  in  1  1 = write
- mem_addr_i  in  ADDR_W  data byte address
- mem_wdata_i  in  DATA_W  write data
- mem_sel_i  in  DATA_W/8  byte enables, bit i = byte i
- mem_rdata_o  out  DATA_W  read word, valid with mem_done_o, held
- mem_done_o  out  1  one-cycle completion pulse
- bus_valid_o  out  1  beat issued this cycle
- bus_we_o  out  1  beat is a write
- bus_addr_o  out  ADDR_W  beat byte address
- bus_wdata_o  out  BEAT_W  beat write data
- bus_rdata_i  in  BEAT_W  read return data
- stallreq_o  out  1  to pipeline controller

Behaviour:
- Reset (rst low at a clock edge): every output goes to 0. FSM goes to IDLE. Beat counters, return counters and assembly registers are cleared. Read data still in flight is discarded, and no done pulse is produced. Reset mid-transfer aborts the transfer.
- N = DATA_W/BEAT_W beats per word. Beat k address = base + k*(BEAT_W/8). Beat k uses word bits [k*BEAT_W +: BEAT_W], little-endian.
- FSM states: IDLE, IF_XFER, MEM_XFER, DONE.
- IDLE:
  - Samples requests each cycle.
  - Only mem_req → MEM_XFER. Only if_req → IF_XFER.
  - Both requested: grant goes to the port not served last; after reset the data port wins.
  - Base address, we, wdata and sel are latched on grant.
- XFER read:
  - Beats 0..N-1 are issued on consecutive cycles, beat 0 in the first XFER cycle.
  - A beat issued in cycle c has its data on bus_rdata_i in cycle c+RD_LAT; the data is captured at that cycle's edge.
  - After the last beat's data is captured → DONE.
  - Total: request sampled in cycle t → done pulse in cycle t+N+RD_LAT+1.
- XFER write:
  - A beat is issued only if any sel bit in its byte range is set; other beats are skipped with no bus cycle.
  - M issued beats go on consecutive cycles t+1..t+M → DONE, pulse in cycle t+M+1.
  - sel all zero → no bus activity, done pulse at t+1.
- Bus outputs: bus_addr_o, bus_we_o and bus_wdata_o are zero whenever bus_valid_o is 0.
- DONE:
  - Exactly one cycle; the granted port's done pulses and its data register updates (reads only).
  - Requests are not sampled; the next state is IDLE.
  - Requesters drop or renew req at the edge where they see done.
- Write completion: a write leaves mem_rdata_o unchanged.
- stallreq_o = mem_req_i & ~mem_done_o (combinational).

Test Plan:
- Read fetch, defaults: if_req_i=1, if_addr_i=0x100 sampled in cycle 0; memory bytes 0x100..0x103 = 11,22,33,44 → bus reads at 0x100..0x103 in cycles 1–4, if_done_o=1 in cycle 6, if_data_o=0x44332211, held afterwards.
- Partial write: mem_we_i=1, addr 0x200, wdata 0xAABBCCDD, sel 4'b0110 → exactly two beats: (0x201, 0xCC) cycle 1, (0x202, 0xBB) cycle 2; mem_done_o in cycle 3; stallreq_o high cycles 0–2.
- Simultaneous requests after reset → data port served first; IF granted next. Then repeat with mem_req_i reasserted immediately → IF still served before the second data access (alternation).
- Reset during read: rst low during the beat-2 issue cycle → next cycle all outputs 0, no done pulse, late bus_rdata_i ignored. A subsequent fetch completes with correct data and normal timing.
- Parameterisation: BEAT_W=16, RD_LAT=3, read at 0x40 with halfwords 0x2211 and 0x4433 → beats at 0x40 and 0x42, done at cycle 2+3+1=6, data 0x44332211.
- Empty write: sel 4'b0000 → bus_valid_o never asserted, mem_done_o one cycle after sampling.
